// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot, run, trap/return, halt.
// Optional PC_BOUND_CHECK_EN traps illegal user redirects below USER_BASE.
module pc_sequencer #(
  parameter logic [11:0] RESET_PC  = 12'd0,
  parameter logic [11:0] USER_BASE = 12'd512,
  parameter logic [11:0] OS_VECTOR = 12'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt_req,
  input  logic        syscall,
  input  logic        os_return,
  input  logic        redirect_valid,
  input  logic [11:0] redirect_addr,
  input  logic        stall,
  output logic [11:0] pc,
  output logic        pc_valid,
  output logic        os_mode,
  output logic [11:0] epc,
  output logic        fault,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    BOOT   = 2'b00,
    RUN    = 2'b01,
    TRAP   = 2'b10,
    HALTED = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [11:0] epc_q, epc_d;
  logic        os_mode_q, os_mode_d;
  logic        pc_valid_q, pc_valid_d;
  logic        fault_q, fault_d;

  // Next-state: prioritised RUN actions; BOOT and TRAP are single bubbles.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    os_mode_d = os_mode_q;
    fault_d   = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (halt_req) begin
          state_d = HALTED;
        end else if (syscall && !os_mode_q) begin
          epc_d     = pc_q + 12'd1;
          pc_d      = OS_VECTOR;
          os_mode_d = 1'b1;
          state_d   = TRAP;
        end else if (os_return && os_mode_q) begin
          pc_d      = epc_q;
          os_mode_d = 1'b0;
          state_d   = TRAP;
        end else if (redirect_valid) begin
`ifdef PC_BOUND_CHECK_EN
          if (!os_mode_q && (redirect_addr < USER_BASE)) begin
            epc_d     = pc_q;
            pc_d      = OS_VECTOR;
            os_mode_d = 1'b1;
            state_d   = TRAP;
            fault_d   = 1'b1;
          end else begin
            pc_d = redirect_addr;
          end
`else
          pc_d = redirect_addr;
`endif
        end else if (!stall) begin
          pc_d = pc_q + 12'd1;
        end
      end
      TRAP:    state_d = RUN;
      HALTED:  state_d = HALTED;
      default: state_d = BOOT;
    endcase
    pc_valid_d = (state_d == RUN);
  end

  // State register with asynchronous reset to the OS entry point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      epc_q      <= USER_BASE;
      os_mode_q  <= 1'b1;
      pc_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      os_mode_q  <= os_mode_d;
      pc_valid_q <= pc_valid_d;
      fault_q    <= fault_d;
    end
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign os_mode  = os_mode_q;
  assign epc      = epc_q;
  assign fault    = fault_q;
  assign state    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer.
// Build with +define+PC_BOUND_CHECK_EN to cover the bounds-check variant.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        halt_req;
  logic        syscall;
  logic        os_return;
  logic        redirect_valid;
  logic [11:0] redirect_addr;
  logic        stall;
  logic [11:0] pc;
  logic        pc_valid;
  logic        os_mode;
  logic [11:0] epc;
  logic        fault;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] S_BOOT = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_TRAP = 2'b10;
  localparam logic [1:0] S_HALT = 2'b11;

  pc_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .halt_req       (halt_req),
    .syscall        (syscall),
    .os_return      (os_return),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .stall          (stall),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .os_mode        (os_mode),
    .epc            (epc),
    .fault          (fault),
    .state          (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs,
                     input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st,
                         input logic [11:0] p, input logic v,
                         input logic om);
    chk({tag, ".state"}, {10'd0, state}, {10'd0, st});
    chk({tag, ".pc"}, pc, p);
    chk({tag, ".valid"}, {11'd0, pc_valid}, {11'd0, v});
    chk({tag, ".os_mode"}, {11'd0, os_mode}, {11'd0, om});
  endtask

  // Apply inputs for one cycle, then sample 1 time unit after the edge.
  task automatic cyc(input logic h, input logic s, input logic o,
                     input logic rv, input logic [11:0] ra,
                     input logic st);
    halt_req       = h;
    syscall        = s;
    os_return      = o;
    redirect_valid = rv;
    redirect_addr  = ra;
    stall          = st;
    @(posedge clk);
    #1;
    halt_req       = 1'b0;
    syscall        = 1'b0;
    os_return      = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 12'd0;
    stall          = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    halt_req       = 1'b0;
    syscall        = 1'b0;
    os_return      = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 12'd0;
    stall          = 1'b0;
    #12;
    chk_all("rst", S_BOOT, 12'd0, 1'b0, 1'b1);
    chk("rst.epc", epc, 12'd512);
    chk("rst.fault", {11'd0, fault}, 12'd0);

    rst_n = 1'b1;
    chk_all("boot", S_BOOT, 12'd0, 1'b0, 1'b1);
    cyc(0, 0, 0, 0, 12'd0, 0);
    chk_all("run0", S_RUN, 12'd0, 1'b1, 1'b1);
    cyc(0, 0, 0, 0, 12'd0, 0);
    chk_all("run1", S_RUN, 12'd1, 1'b1, 1'b1);
    cyc(0, 0, 0, 0, 12'd0, 0);
    chk_all("run2", S_RUN, 12'd2, 1'b1, 1'b1);

    // OS-mode syscall falls through to the redirect
    cyc(0, 1, 0, 1, 12'd50, 0);
    chk_all("os_sys_ign", S_RUN, 12'd50, 1'b1, 1'b1);

    // Return to user at the reset epc
    cyc(0, 0, 1, 0, 12'd0, 0);
    chk_all("ret0", S_TRAP, 12'd512, 1'b0, 1'b0);
    cyc(0, 1, 0, 1, 12'd9, 0);
    chk_all("ret0_bub", S_RUN, 12'd512, 1'b1, 1'b0);

    // User-mode os_return falls through to the redirect
    cyc(0, 0, 1, 1, 12'd600, 0);
    chk_all("usr_ret_ign", S_RUN, 12'd600, 1'b1, 1'b0);

    cyc(0, 1, 0, 0, 12'd0, 0);
    chk_all("sys", S_TRAP, 12'd1, 1'b0, 1'b1);
    chk("sys.epc", epc, 12'd601);
    cyc(0, 0, 0, 0, 12'd0, 0);
    chk_all("sys_bub", S_RUN, 12'd1, 1'b1, 1'b1);
    cyc(0, 0, 0, 0, 12'd0, 0);
    chk_all("os_inc", S_RUN, 12'd2, 1'b1, 1'b1);

    cyc(0, 0, 1, 0, 12'd0, 0);
    chk_all("ret1", S_TRAP, 12'd601, 1'b0, 1'b0);
    cyc(0, 0, 0, 0, 12'd0, 0);
    chk_all("ret1_bub", S_RUN, 12'd601, 1'b1, 1'b0);

    cyc(0, 0, 0, 1, 12'd700, 1);
    chk_all("redir_stall", S_RUN, 12'd700, 1'b1, 1'b0);
    cyc(0, 0, 0, 0, 12'd0, 1);
    chk_all("stall", S_RUN, 12'd700, 1'b1, 1'b0);
    chk("stall.epc", epc, 12'd601);

    cyc(0, 0, 0, 1, 12'd4095, 0);
    chk_all("to_max", S_RUN, 12'd4095, 1'b1, 1'b0);
    cyc(0, 0, 0, 0, 12'd0, 0);
    chk_all("wrap", S_RUN, 12'd0, 1'b1, 1'b0);

    cyc(0, 0, 0, 1, 12'd520, 0);
    chk_all("to520", S_RUN, 12'd520, 1'b1, 1'b0);
    cyc(0, 0, 0, 1, 12'd100, 0);
`ifdef PC_BOUND_CHECK_EN
    chk_all("bound", S_TRAP, 12'd1, 1'b0, 1'b1);
    chk("bound.epc", epc, 12'd520);
    chk("bound.fault", {11'd0, fault}, 12'd1);
    cyc(0, 0, 0, 0, 12'd0, 0);
    chk_all("bound_bub", S_RUN, 12'd1, 1'b1, 1'b1);
    chk("bound_bub.fault", {11'd0, fault}, 12'd0);
    cyc(0, 0, 0, 1, 12'd100, 0);
    chk_all("os_low_redir", S_RUN, 12'd100, 1'b1, 1'b1);
    chk("os_low.fault", {11'd0, fault}, 12'd0);
`else
    chk_all("nobound", S_RUN, 12'd100, 1'b1, 1'b0);
    chk("nobound.fault", {11'd0, fault}, 12'd0);
    chk("nobound.epc", epc, 12'd601);
`endif

    cyc(1, 1, 0, 0, 12'd0, 0);
    chk_all("halt", S_HALT, 12'd100, 1'b0, os_mode);
    chk("halt.state2", {10'd0, state}, {10'd0, S_HALT});
    cyc(0, 1, 1, 1, 12'd900, 0);
    chk("halted.pc", pc, 12'd100);
    chk("halted.state", {10'd0, state}, {10'd0, S_HALT});
    chk("halted.valid", {11'd0, pc_valid}, 12'd0);

    rst_n = 1'b0;
    #1;
    chk_all("arst", S_BOOT, 12'd0, 1'b0, 1'b1);
    chk("arst.epc", epc, 12'd512);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 12'd0, 0);
    chk_all("arst_run", S_RUN, 12'd0, 1'b1, 1'b1);

    // Reset during a trap bubble discards the epc update
    cyc(0, 0, 1, 0, 12'd0, 0);
    chk_all("ret2", S_TRAP, 12'd512, 1'b0, 1'b0);
    cyc(0, 0, 0, 0, 12'd0, 0);
    cyc(0, 1, 0, 0, 12'd0, 0);
    chk_all("sys2", S_TRAP, 12'd1, 1'b0, 1'b1);
    chk("sys2.epc", epc, 12'd513);
    rst_n = 1'b0;
    #1;
    chk_all("trap_rst", S_BOOT, 12'd0, 1'b0, 1'b1);
    chk("trap_rst.epc", epc, 12'd512);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 12'd0, 0);
    chk_all("trap_rst_run", S_RUN, 12'd0, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, 12'd0, PC loaded at reset (OS entry).
REQ-002 Parameter USER_BASE, 12'd512, lowest legal user-space ROM address.
REQ-003 Parameter OS_VECTOR, 12'd1, OS handler address for syscall and fault entry.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 halt_req  in  1  stop fetching permanently until reset.
REQ-007 syscall  in  1  user-to-OS trap request.
REQ-008 os_return  in  1  OS-to-user return request.
REQ-009 redirect_valid  in  1  brancher reports a taken jump or branch.
REQ-010 redirect_addr  in  12  absolute target ROM address, user offset already applied.
REQ-011 stall  in  1  hold the current PC.
REQ-012 pc  out  12  current fetch address.
REQ-013 pc_valid  out  1  pc is a valid fetch this cycle.
REQ-014 os_mode  out  1  1 = OS, 0 = user; drives the brancher OSUsage input.
REQ-015 epc  out  12  saved user resume address.
REQ-016 fault  out  1  one-cycle pulse on an illegal user redirect.
REQ-017 state  out  2  BOOT=00, RUN=01, TRAP=10, HALTED=11.

Function
REQ-018 FSM BOOT->RUN unconditionally after one cycle; all inputs are ignored in BOOT.
REQ-019 RUN priority, highest first: halt_req > syscall > os_return > redirect_valid > stall > increment.
REQ-020 halt_req in RUN: state<=HALTED and pc holds; HALTED exits only through rst_n.
REQ-021 syscall in RUN with os_mode=0: epc<=pc+1, pc<=OS_VECTOR, os_mode<=1, state<=TRAP.
REQ-022 syscall in RUN with os_mode=1: ignored; evaluation falls through to the lower priorities.
REQ-023 os_return in RUN with os_mode=1: pc<=epc, os_mode<=0, state<=TRAP.
REQ-024 os_return with os_mode=0: ignored; evaluation falls through to the lower priorities.
REQ-025 redirect_valid in RUN: pc<=redirect_addr; the redirect takes effect even when stall=1.
REQ-026 stall alone in RUN: pc, epc and os_mode hold.
REQ-027 Increment: pc<=pc+1, modulo 4096; 12'hFFF wraps to 12'h000 with no flag.
REQ-028 TRAP lasts exactly one cycle as a bubble, then returns to RUN; all inputs are ignored in TRAP.
REQ-029 pc_valid=1 only in RUN; it is 0 in BOOT, TRAP and HALTED (registered, same cycle as state).
REQ-030 fault=0 in every cycle except as defined in REQ-038.
REQ-031 All outputs are registered; redirect, trap and return take effect with one-cycle latency (visible on the next edge).

Reset
REQ-032 rst_n low asynchronously forces pc=RESET_PC, os_mode=1, epc=USER_BASE, state=BOOT, pc_valid=0, fault=0.
REQ-033 rst_n asserted mid-TRAP or mid-redirect discards the pending update; no partial epc write survives.
REQ-034 Release of rst_n is taken on the next rising clk edge; the first RUN cycle follows one BOOT cycle.

Configuration
REQ-035 Macro PC_BOUND_CHECK_EN selects user-mode redirect bounds checking.
REQ-036 Without PC_BOUND_CHECK_EN: redirect_addr is always taken as-is, and fault is tied 0.
REQ-037 With PC_BOUND_CHECK_EN: the check applies in RUN when os_mode=0, redirect_valid=1 and redirect_addr<USER_BASE.
REQ-038 On a REQ-037 violation: epc<=pc, pc<=OS_VECTOR, os_mode<=1, state<=TRAP, fault=1 for one cycle.
REQ-039 With PC_BOUND_CHECK_EN, a redirect in OS mode is never checked.

Verification
REQ-040 Reset release then 3 clean cycles -> state BOOT,RUN,RUN,RUN; pc 0,0,1,2; pc_valid 0,1,1,1.
REQ-041 User mode at pc=600, syscall -> pc=1, os_mode=1, epc=601, one TRAP bubble; later os_return -> pc=601, os_mode=0.
REQ-042 Same cycle redirect_valid=1 (addr 700) and stall=1 -> pc=700; next cycle stall=1 alone -> pc stays 700.
REQ-043 pc=4095, no requests -> pc=0 on the next cycle, pc_valid stays 1.
REQ-044 With PC_BOUND_CHECK_EN, user pc=520 and redirect to 100 -> fault pulse, pc=1, epc=520; without the macro -> pc=100, fault=0.
REQ-045 halt_req and syscall together -> HALTED, pc held, pc_valid=0; rst_n pulse -> BOOT with pc=0.
